// File: rtl/bcd_conv_sched_if.sv
// Request/result bundle between the clock-display requesters and the shared
// binary-to-BCD conversion engine.
interface bcd_conv_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 12,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] bin_in;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [3:0]            thos;
    logic [3:0]            hund;
    logic [3:0]            tens;
    logic [3:0]            ones;

    modport master (
        output req, bin_in,
        input  grant, busy, done, done_id, thos, hund, tens, ones
    );

    modport slave (
        input  req, bin_in,
        output grant, busy, done, done_id, thos, hund, tens, ones
    );
endinterface

// File: rtl/bcd_conv_sched.sv
// Round-robin arbitrated, iterative double-dabble binary-to-BCD converter
// shared by all clock-display requesters.
module bcd_conv_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 12,
    parameter int IDW   = 2
) (
    input logic              clk,
    input logic              reset,
    bcd_conv_sched_if.slave  bus
);
    localparam int CNTW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic                load_s;
    logic                shift_s;
    logic                finish_s;
    logic [CNTW-1:0]     cnt_r;
    logic [15:0]         bcd_r;
    logic [WIDTH-1:0]    op_r;
    logic [IDW-1:0]      win_r;
    logic [IDW-1:0]      ptr_r;
    logic [IDW-1:0]      pick_s;
    logic [15+WIDTH:0]   step_s;
    logic [NREQ-1:0]     grant_r;
    logic                busy_r;
    logic                done_r;
    logic [IDW-1:0]      done_id_r;
    logic [15:0]         digits_r;

    // First requester at or above the pointer, wrapping; falls back to ptr when none.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] idx;
        logic           found;
        int             sum;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            sum   = int'(ptr) + i;
            sum   = (sum >= NREQ) ? (sum - NREQ) : sum;
            idx   = sum[IDW-1:0];
            pick  = (!found && req[idx]) ? idx : pick;
            found = found | req[idx];
        end
        return pick;
    endfunction

    // One shift-add-3 iteration over the {bcd, operand} pair.
    function automatic logic [15+WIDTH:0] dd_step(input logic [15:0]      bcd,
                                                  input logic [WIDTH-1:0] op);
        logic [15:0] adj;
        for (int k = 0; k < 4; k++) begin
            adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? (bcd[4*k +: 4] + 4'd3)
                                                    : bcd[4*k +: 4];
        end
        return {adj[14:0], op, 1'b0};
    endfunction

    // Arbitration choice and next datapath value.
    always_comb begin
        pick_s = rr_pick(bus.req, ptr_r);
        step_s = dd_step(bcd_r, op_r);
    end

    // Next-state and control strobes.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        finish_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_nx_s = ST_SHIFT;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_s = 1'b1;
                if (cnt_r == CNTW'(1)) begin
                    state_nx_s = ST_DONE;
                    finish_s   = 1'b1;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath, arbitration pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= {CNTW{1'b0}};
            bcd_r     <= 16'h0000;
            op_r      <= {WIDTH{1'b0}};
            win_r     <= {IDW{1'b0}};
            ptr_r     <= {IDW{1'b0}};
            grant_r   <= {NREQ{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            done_id_r <= {IDW{1'b0}};
            digits_r  <= 16'h0000;
        end else begin
            grant_r <= {NREQ{1'b0}};
            done_r  <= 1'b0;
            if (load_s) begin
                op_r    <= bus.bin_in[int'(pick_s)*WIDTH +: WIDTH];
                bcd_r   <= 16'h0000;
                cnt_r   <= CNTW'(WIDTH);
                win_r   <= pick_s;
                ptr_r   <= (pick_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : (pick_s + 1'b1);
                grant_r <= {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
                busy_r  <= 1'b1;
            end else if (shift_s) begin
                bcd_r <= step_s[15+WIDTH:WIDTH];
                op_r  <= step_s[WIDTH-1:0];
                cnt_r <= cnt_r - 1'b1;
                // The last iteration feeds the outputs directly so done lands in the DONE cycle.
                if (finish_s) begin
                    digits_r  <= step_s[15+WIDTH:WIDTH];
                    done_id_r <= win_r;
                    done_r    <= 1'b1;
                end else begin
                    digits_r <= digits_r;
                end
            end else if (state_r == ST_DONE) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    assign bus.grant   = grant_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.done_id = done_id_r;
    assign bus.thos    = digits_r[15:12];
    assign bus.hund    = digits_r[11:8];
    assign bus.tens    = digits_r[7:4];
    assign bus.ones    = digits_r[3:0];
endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched: round-robin order and decimal digits are
// predicted from plain arithmetic and compared by an independent monitor.
module tb_bcd_conv_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 12;
    localparam int IDW   = 2;

    typedef struct {
        int id;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    bcd_conv_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    bcd_conv_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          gcyc_q[$];
    int          n_pass = 0;
    int          n_chk  = 0;
    int          cyc    = 0;
    int          grant_cyc = 0;
    int          done_cnt  = 0;
    logic [15:0] hold_dig  = 16'h0000;
    int          hold_id   = 0;
    int          mdl_ptr   = 0;
    bit          reraise   = 1'b0;
    int          served[NREQ];
    bit          rr_pend[NREQ];
    int          ops[12];

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: pops the scoreboard whenever the engine reports a result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (bus.grant !== '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", int'(bus.grant), 0);
                    end else begin
                        chk("grant_onehot", int'(bus.grant), 1 << exp_q[0].id);
                    end
                    chk("busy_at_grant", int'(bus.busy), 1);
                    grant_cyc = cyc;
                    gcyc_q.push_back(cyc);
                end
                if (bus.done === 1'b1) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_id", int'(bus.done_id), e.id);
                        chk("digits", int'({bus.thos, bus.hund, bus.tens, bus.ones}), int'(to_bcd(e.val)));
                        chk("done_latency", cyc - grant_cyc, WIDTH);
                        chk("busy_at_done", int'(bus.busy), 1);
                        hold_dig = to_bcd(e.val);
                        hold_id  = e.id;
                    end
                end else begin
                    chk("hold_digits", int'({bus.thos, bus.hund, bus.tens, bus.ones}), int'(hold_dig));
                    chk("hold_id", int'(bus.done_id), hold_id);
                end
            end
        end
    end

    // Advance one cycle; requesters drop req on grant and optionally re-raise a cycle later.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (rr_pend[i]) begin
                bus.bin_in[i*WIDTH +: WIDTH] = WIDTH'(ops[served[i]*NREQ + i]);
                bus.req[i] = 1'b1;
                rr_pend[i] = 1'b0;
            end
            if (bus.grant[i] === 1'b1) begin
                bus.req[i] = 1'b0;
                if (reraise && served[i] < 2) begin
                    served[i]++;
                    rr_pend[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        hold_dig = 16'h0000;
        hold_id  = 0;
        mdl_ptr  = 0;
        bus.req  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        clear_model();
        step();
        reset = 1'b0;
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_done_id", int'(bus.done_id), 0);
        chk("rst_digits", int'({bus.thos, bus.hund, bus.tens, bus.ones}), 0);
    endtask

    // Raise a set of requests together; the model serves them in cyclic order from its pointer.
    task automatic issue(input logic [NREQ-1:0] mask, input int v[NREQ]);
        int id;
        int last;
        last = -1;
        for (int j = 0; j < NREQ; j++) begin
            id = (mdl_ptr + j) % NREQ;
            if (mask[id]) begin
                exp_q.push_back('{id: id, val: v[id]});
                last = id;
            end
        end
        if (last >= 0) mdl_ptr = (last + 1) % NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) begin
                bus.bin_in[i*WIDTH +: WIDTH] = WIDTH'(v[i]);
                bus.req[i] = 1'b1;
            end
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        bus.req = '0;
        step();
    endtask

    task automatic wait_grant(input int max_cyc);
        int n;
        n = 0;
        while (bus.grant === '0 && n < max_cyc) begin
            step();
            n++;
        end
        chk("grant_seen", int'(bus.grant !== '0), 1);
    endtask

    initial begin
        int          v[NREQ];
        int          c;
        int          dc;
        int          k;
        logic [NREQ-1:0] m;
        int          bvals[4];

        reset      = 1'b1;
        bus.req    = '0;
        bus.bin_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            served[i]  = 0;
            rr_pend[i] = 1'b0;
            v[i]       = 0;
        end
        do_reset();

        // Full-scale operand on requester 0, with grant latency.
        v[0] = 4095;
        c = cyc;
        gcyc_q.delete();
        issue(4'b0001, v);
        drain(40);
        chk("grant_latency_t1", gcyc_q.size() > 0 ? gcyc_q[0] - c : -1, 1);

        // Decimal boundaries on requester 1.
        bvals = '{0, 999, 1000, 10};
        for (int b = 0; b < 4; b++) begin
            v[1] = bvals[b];
            issue(4'b0010, v);
            drain(40);
        end

        // Two simultaneous requests after reset: back-to-back spacing.
        do_reset();
        gcyc_q.delete();
        v[0] = int'($urandom_range(0, 4095));
        v[2] = int'($urandom_range(0, 4095));
        issue(4'b0101, v);
        drain(60);
        chk("rr_grant_count", gcyc_q.size(), 2);
        chk("rr_gap", gcyc_q.size() >= 2 ? gcyc_q[1] - gcyc_q[0] : -1, WIDTH + 2);

        // All four held and re-raised: strict rotation over 12 conversions.
        do_reset();
        for (int j = 0; j < 12; j++) begin
            ops[j] = int'($urandom_range(0, 4095));
            exp_q.push_back('{id: j % NREQ, val: ops[j]});
        end
        for (int i = 0; i < NREQ; i++) begin
            served[i] = 0;
            bus.bin_in[i*WIDTH +: WIDTH] = WIDTH'(ops[i]);
        end
        reraise = 1'b1;
        bus.req = 4'b1111;
        drain(250);
        reraise = 1'b0;
        for (int i = 0; i < NREQ; i++) rr_pend[i] = 1'b0;
        mdl_ptr = 0;

        // Random request sets and operands.
        for (int r = 0; r < 12; r++) begin
            m = NREQ'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) v[i] = int'($urandom_range(0, 4095));
            issue(m, v);
            drain(80);
        end

        // Operand and other requests disturbed during the conversion.
        k = int'($urandom_range(0, NREQ - 1));
        v[k] = int'($urandom_range(0, 4095));
        issue(NREQ'(1 << k), v);
        wait_grant(5);
        for (int t = 2; t <= WIDTH + 2; t++) begin
            step();
            chk("grant_quiet", int'(bus.grant), 0);
            if (t <= 10) begin
                bus.bin_in = {$urandom, $urandom};
                m = NREQ'($urandom_range(0, 15));
                m[k] = 1'b0;
                bus.req = m;
            end else begin
                bus.req = '0;
            end
        end
        drain(5);

        // Reset in the middle of a conversion.
        v[0] = 1234;
        issue(4'b0001, v);
        wait_grant(5);
        repeat (4) step();
        reset = 1'b1;
        step();
        clear_model();
        reset = 1'b0;
        chk("midrst_grant", int'(bus.grant), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_done_id", int'(bus.done_id), 0);
        chk("midrst_digits", int'({bus.thos, bus.hund, bus.tens, bus.ones}), 0);
        dc = done_cnt;
        repeat (20) step();
        chk("midrst_no_done", done_cnt, dc);
        v[3] = 59;
        gcyc_q.delete();
        c = cyc;
        issue(4'b1000, v);
        drain(30);
        chk("grant_latency_t5", gcyc_q.size() > 0 ? gcyc_q[0] - c : -1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
